// File: rtl/cpu24_pkg.sv
// Shared definitions for the 24-bit CPU run controller: widths, default run length, run states.
package cpu24_pkg;

    localparam int unsigned CPU24_WIDTH       = 24;
    localparam int unsigned CPU24_DEFAULT_RUN = 30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } run_state_e;

endpackage

// File: rtl/cpu24_cycle_counter.sv
// Executed-cycle counter with synchronous clear, increment enable and natural wrap.
// last_c flags that the next increment lands on the programmed limit.
module cpu24_cycle_counter
    import cpu24_pkg::*;
#(
    parameter int unsigned WIDTH = CPU24_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             last_c
);

    logic [WIDTH-1:0] count_inc_c;

    assign count_inc_c = count + WIDTH'(1);
    assign last_c      = (count_inc_c == limit);

    // Clear wins over increment so a restart always begins from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count_inc_c;
        end
    end

endmodule

// File: rtl/cpu24_run_ctrl.sv
// Run controller for the 24-bit CPU: Start/Step/Halt command FSM driving a registered
// core enable, with a programmable cycle limit and optional free-running mode.
module cpu24_run_ctrl
    import cpu24_pkg::*;
#(
    parameter int unsigned WIDTH         = CPU24_WIDTH,
    parameter int unsigned DEFAULT_LIMIT = CPU24_DEFAULT_RUN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic             halt,
    input  logic             free_run,
    input  logic [WIDTH-1:0] cycle_limit,
    output logic             cpu_enable,
    output logic [WIDTH-1:0] cycle_count,
    output logic             busy,
    output logic             done
);

    run_state_e       state_q;
    run_state_e       state_d;
    logic [WIDTH-1:0] limit_q;
    logic             free_q;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             latch;
    logic             last_c;

    cpu24_cycle_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .limit  (limit_q),
        .count  (cycle_count),
        .last_c (last_c)
    );

    // Next-state and counter control; Halt outranks Start, Start outranks Step.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        latch   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (halt) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                    cnt_clr = 1'b1;
                    latch   = 1'b1;
                end else if (step && (state_q == IDLE)) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (halt) begin
                    // The cycle ending at the halt edge was executed, so it is counted.
                    state_d = IDLE;
                    cnt_inc = 1'b1;
                end else if (start) begin
                    cnt_clr = 1'b1;
                    latch   = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                    if (!free_q && last_c) begin
                        state_d = DONE;
                    end
                end
            end
            STEP: begin
                state_d = IDLE;
                cnt_inc = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Run configuration is captured only on an accepted Start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            limit_q <= WIDTH'(DEFAULT_LIMIT);
            free_q  <= 1'b0;
        end else if (latch) begin
            limit_q <= (cycle_limit == '0) ? WIDTH'(DEFAULT_LIMIT) : cycle_limit;
            free_q  <= free_run;
        end
    end

    // Status flops track the state register exactly, one flop per output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            cpu_enable <= (state_d == RUN) || (state_d == STEP);
            busy       <= (state_d == RUN) || (state_d == STEP);
            done       <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_cpu24_run_ctrl.sv
// Self-checking bench for cpu24_run_ctrl: cycle-accurate behavioural model plus directed scenarios,
// and a reduced-width instance that exercises counter wrap in free-run mode.
module tb_cpu24_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, step, halt, free_run;
    logic [23:0] cycle_limit;
    logic        cpu_enable, busy, done;
    logic [23:0] cycle_count;

    logic        s_start, s_step, s_halt, s_free;
    logic [3:0]  s_limit;
    logic        s_en, s_busy, s_done;
    logic [3:0]  s_count;

    int n_checks = 0;
    int n_fail   = 0;
    int en_total = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    cpu24_run_ctrl u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .step        (step),
        .halt        (halt),
        .free_run    (free_run),
        .cycle_limit (cycle_limit),
        .cpu_enable  (cpu_enable),
        .cycle_count (cycle_count),
        .busy        (busy),
        .done        (done)
    );

    cpu24_run_ctrl #(.WIDTH(4), .DEFAULT_LIMIT(5)) u_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (s_start),
        .step        (s_step),
        .halt        (s_halt),
        .free_run    (s_free),
        .cycle_limit (s_limit),
        .cpu_enable  (s_en),
        .cycle_count (s_count),
        .busy        (s_busy),
        .done        (s_done)
    );

    // Behavioural view: is the core running a program, doing one step, or finished?
    typedef struct {
        int cnt;
        bit running;
        bit stepping;
        bit finished;
        int lim;
        bit free;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.cnt = 0; r.running = 0; r.stepping = 0; r.finished = 0; r.lim = 30; r.free = 0;
        return r;
    endfunction

    function automatic model_t launch(model_t s, bit fr, int lim);
        model_t n = s;
        n.cnt = 0; n.running = 1; n.stepping = 0; n.finished = 0;
        n.lim = (lim == 0) ? 30 : lim;
        n.free = fr;
        return n;
    endfunction

    function automatic model_t model_next(model_t s, bit st, bit sp, bit hl, bit fr, int lim);
        model_t n = s;
        if (s.stepping) begin
            n.cnt = (s.cnt + 1) % (1 << 24);
            n.stepping = 0;
        end else if (s.running) begin
            if (hl) begin
                n.cnt = (s.cnt + 1) % (1 << 24);
                n.running = 0;
            end else if (st) begin
                n = launch(s, fr, lim);
            end else begin
                n.cnt = (s.cnt + 1) % (1 << 24);
                if (!s.free && n.cnt == s.lim) begin
                    n.running = 0;
                    n.finished = 1;
                end
            end
        end else begin
            if (hl) n.finished = 0;
            else if (st) n = launch(s, fr, lim);
            else if (sp && !s.finished) n.stepping = 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_next(m, start, step, halt, free_run, int'(cycle_limit));
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model cpu_enable", longint'(cpu_enable), longint'(m.running || m.stepping));
            chk("model busy", longint'(busy), longint'(m.running || m.stepping));
            chk("model done", longint'(done), longint'(m.finished));
            chk("model cycle_count", longint'(cycle_count), longint'(m.cnt));
        end
    end

    always @(negedge clk) if (cpu_enable) en_total++;

    task automatic cmd(input bit st, input bit sp, input bit hl, input bit fr, input logic [23:0] lim);
        @(posedge clk); #1;
        start = st; step = sp; halt = hl; free_run = fr; cycle_limit = lim;
        @(posedge clk); #1;
        start = 0; step = 0; halt = 0;
    endtask

    task automatic wait_done(input string name, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk(name, longint'(done), 1);
    endtask

    int snap;

    initial begin
        rst_n = 0; start = 0; step = 0; halt = 0; free_run = 0; cycle_limit = '0;
        s_start = 0; s_step = 0; s_halt = 0; s_free = 0; s_limit = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset cpu_enable", longint'(cpu_enable), 0);
        chk("reset count", longint'(cycle_count), 0);
        chk("reset busy+done", longint'({busy, done}), 0);
        @(negedge clk); rst_n = 1; chk_en = 1;

        // Default limit run.
        #1 snap = en_total;
        cmd(1, 0, 0, 0, 24'd0);
        wait_done("default run done", 100);
        chk("default enables", longint'(en_total - snap), 30);
        chk("default count", longint'(cycle_count), 30);
        chk("default en off", longint'(cpu_enable), 0);

        // Limit 5 then restart from DONE with limit 3.
        #1 snap = en_total;
        cmd(1, 0, 0, 0, 24'd5);
        wait_done("lim5 done", 50);
        chk("lim5 enables", longint'(en_total - snap), 5);
        chk("lim5 count", longint'(cycle_count), 5);
        #1 snap = en_total;
        cmd(1, 0, 0, 0, 24'd3);
        wait_done("lim3 done", 50);
        chk("lim3 enables", longint'(en_total - snap), 3);
        chk("lim3 count", longint'(cycle_count), 3);

        // Limit 1.
        #1 snap = en_total;
        cmd(1, 0, 0, 0, 24'd1);
        wait_done("lim1 done", 20);
        chk("lim1 enables", longint'(en_total - snap), 1);

        // Halt after 10 cycles, then three steps.
        cmd(1, 0, 0, 0, 24'd30);
        repeat (8) @(posedge clk);
        cmd(0, 0, 1, 0, 24'd30);
        @(negedge clk);
        chk("halt count", longint'(cycle_count), 10);
        chk("halt busy", longint'(busy), 0);
        repeat (3) cmd(0, 1, 0, 0, 24'd30);
        @(posedge clk); #1;
        chk("steps count", longint'(cycle_count), 13);
        chk("steps done", longint'(done), 0);

        // Combined commands in IDLE.
        cmd(1, 1, 1, 0, 24'd6);
        @(negedge clk);
        chk("all cmds busy", longint'(busy), 0);
        chk("all cmds count", longint'(cycle_count), 13);
        #1 snap = en_total;
        cmd(1, 1, 0, 0, 24'd6);
        @(negedge clk);
        chk("start+step busy", longint'(busy), 1);
        chk("start+step count", longint'(cycle_count), 0);
        cmd(0, 1, 0, 0, 24'd6);
        wait_done("step-in-run done", 50);
        chk("step-in-run enables", longint'(en_total - snap), 6);

        // Reset in the middle of a run.
        cmd(1, 0, 0, 0, 24'd30);
        repeat (12) @(posedge clk);
        #3;
        chk("pre-reset count", longint'(cycle_count), 12);
        rst_n = 0;
        #1;
        chk("mid-reset en", longint'(cpu_enable), 0);
        chk("mid-reset count", longint'(cycle_count), 0);
        chk("mid-reset busy", longint'(busy), 0);
        @(negedge clk); rst_n = 1;
        cmd(0, 1, 0, 0, 24'd0);
        @(posedge clk); #1;
        chk("post-reset step count", longint'(cycle_count), 1);

        // Free-run wrap on the 4-bit instance.
        @(posedge clk); #1;
        s_start = 1; s_free = 1; s_limit = 4'd0;
        @(posedge clk); #1;
        s_start = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("wrap count", longint'(s_count), longint'(i % 16));
            chk("wrap en", longint'(s_en), 1);
        end
        @(posedge clk); #1 s_halt = 1;
        @(posedge clk); #1 s_halt = 0;
        @(negedge clk);
        chk("wrap halt en", longint'(s_en), 0);
        chk("wrap halt count", longint'(s_count), 5);
        chk("wrap done", longint'(s_done), 0);
        chk("wrap busy", longint'(s_busy), 0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
